mvm_ctrl_fsm: RTL and testbench
===============================

# mvm_ctrl_fsm

Sequencing controller for one crossbar MVM. Drives the control side of the `mvm_bus` interface (ctrl modport) into the MVM datapath:

- walks the activation rows one at a time;
- skips zero activations using the datapath's `skip` feedback;
- issues the weight-programming strobe;
- signals completion with a one-cycle `mvm_done`.

It sits beside the MVM datapath inside the core tile and is started by the tile instruction decoder.

## Interface
Parameters:
- `XBAR_SIZE`, default 16: number of activation rows (crossbar dimension).
- `RD_CYCLES`, default 1: cycles `rd_en` is held per row to cover weight-memory read latency; legal range 1–4.
- `CNT_W`, default `$clog2(XBAR_SIZE)`: width of the row counter.

Ports (`dp_bus` signals are carried on `mvm_bus` ctrl modport):
- `clk`  in  1  single clock. Reset is synchronous and active-high (see `reset`).
- `reset`  in  1  synchronous, active-high; forces IDLE and all outputs low.
- `mvm_start`  in  1  request one MVM; sampled only in IDLE.
- `prog_req`  in  1  request one weight-programming strobe; sampled only in IDLE.
- `skip`  in  1  datapath flag: current fetched activation is zero (valid only while `fetch` is high).
- `get_ready`  out  1  clear datapath accumulators and address.
- `fetch`  out  1  latch activation row `counter`, advance weight address.
- `rd_en`  out  1  read weight row into datapath register.
- `calc`  out  1  form products.
- `up_sum`  out  1  accumulate products.
- `prog_wt`  out  1  write `wr_weight` into weight memory.
- `counter`  out  `CNT_W`  current activation row index.
- `mvm_done`  out  1  one-cycle pulse; datapath copies sums to its output memory.
- `busy`  out  1  high in every state except IDLE.

## Operation
- States: IDLE, PROG, INIT, FETCH, READ, CALC, ACC, DONE.
- Outputs are one-hot across {`get_ready`, `fetch`, `rd_en`, `calc`, `up_sum`, `prog_wt`, `mvm_done`}. Each is a registered decode of state and is high only in its matching state. The datapath priority order therefore never matters.
- IDLE: if `prog_req` → PROG. Otherwise, if `mvm_start` → INIT. `prog_req` wins when both are high; `mvm_start` is dropped, not queued.
- PROG → IDLE after exactly one cycle.
- INIT: `counter` is set to 0 → FETCH.
- FETCH: sample `skip`.
  - `skip`=1 and `counter` < `XBAR_SIZE`-1 → `counter`+1, stay in FETCH.
  - `skip`=1 and `counter` = `XBAR_SIZE`-1 → DONE.
  - `skip`=0 → READ.
- READ: held `RD_CYCLES` cycles, counted by an internal down-counter → CALC.
- CALC → ACC.
- ACC: if `counter` = `XBAR_SIZE`-1 → DONE. Otherwise `counter`+1 → FETCH.
- DONE → IDLE. `counter` holds its last value until the next INIT.
- `mvm_start` and `prog_req` asserted outside IDLE are ignored.
- `reset` mid-operation: next cycle is IDLE, every output is 0, `counter` is 0, and no `mvm_done` is emitted.

## Timing
- Reset values: all strobes 0, `busy` 0, `counter` 0.
- Take `mvm_start` sampled at cycle 0. Then:
  - INIT is in cycle 1;
  - the first FETCH is in cycle 2;
  - `mvm_done` is in cycle 2 + nz·(3+`RD_CYCLES`) + z, where nz is the number of non-zero rows and z the number of zero rows (nz+z = `XBAR_SIZE`).
- Back-to-back: a new `mvm_start` is accepted in the cycle after DONE, when the block is in IDLE. Minimum start-to-start spacing is therefore one more cycle than the latency above.
- `prog_req` at cycle 0 → `prog_wt` high in cycle 1 only, and `busy` high in cycle 1 only.
- `skip` is combinational from the datapath during FETCH and is consumed in the same cycle; no extra latency.
- `counter` changes only on the FETCH→FETCH and ACC→FETCH transitions and in INIT. It is stable through READ, CALC and ACC of a row.

## Structure
- Shared package `mvm_pkg` holds:
  - `typedef enum logic [2:0]` for `mvm_state_t` (the eight states above);
  - `XBAR_SIZE` default constant;
  - `RD_CYCLES` default constant.
- Single module, no sub-modules: a state register, row counter and read-latency counter all belong in this one file.

## Test plan
- Reset for 3 cycles, then idle: all outputs 0, `busy` 0.
- `XBAR_SIZE`=16, `RD_CYCLES`=1, all activations non-zero (`skip` held 0):
  - `mvm_done` in cycle 66;
  - strobe order FETCH, READ, CALC, ACC repeated 16 times with `counter` 0..15;
  - strobes one-hot every cycle.
- All activations zero (`skip`=1 whenever `fetch` is high): 16 consecutive `fetch` cycles, no `rd_en`/`calc`/`up_sum`, `mvm_done` in cycle 18.
- Rows 3 and 7 zero, others non-zero, `RD_CYCLES`=2:
  - `mvm_done` in cycle 2+14·5+2 = 74;
  - rows 3 and 7 each occupy exactly one `fetch` cycle;
  - `rd_en` is 2 cycles wide on every other row.
- `prog_req` and `mvm_start` both high in IDLE: one-cycle `prog_wt`, return to IDLE, no INIT. Then `mvm_start` while busy mid-row is ignored (exactly one `mvm_done`).
- `reset` asserted during CALC of row 5: IDLE next cycle, all outputs 0, `counter` 0, no `mvm_done`. A following `mvm_start` runs a full MVM normally.

Source files
------------

// File: rtl/mvm_pkg.sv
// Shared types and defaults for the crossbar MVM control path:
// controller state encoding, strobe bundle and its state decode.
package mvm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PROG  = 3'd1,
        ST_INIT  = 3'd2,
        ST_FETCH = 3'd3,
        ST_READ  = 3'd4,
        ST_CALC  = 3'd5,
        ST_ACC   = 3'd6,
        ST_DONE  = 3'd7
    } mvm_state_t;

    localparam int XBAR_SIZE_DEF = 16;
    localparam int RD_CYCLES_DEF = 1;

    typedef struct packed {
        logic get_ready;
        logic fetch;
        logic rd_en;
        logic calc;
        logic up_sum;
        logic prog_wt;
        logic mvm_done;
    } mvm_strb_t;

    // Exactly one strobe per non-idle state, so the datapath never sees two at once.
    function automatic mvm_strb_t strobe_decode(input mvm_state_t st);
        mvm_strb_t s;
        s = '0;
        case (st)
            ST_PROG:  s.prog_wt   = 1'b1;
            ST_INIT:  s.get_ready = 1'b1;
            ST_FETCH: s.fetch     = 1'b1;
            ST_READ:  s.rd_en     = 1'b1;
            ST_CALC:  s.calc      = 1'b1;
            ST_ACC:   s.up_sum    = 1'b1;
            ST_DONE:  s.mvm_done  = 1'b1;
            ST_IDLE:  s = '0;
            default:  s = '0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/mvm_bus.sv
// Control/feedback bundle between the MVM sequencer and the crossbar datapath.
interface mvm_bus #(
    parameter int CNT_W = 4
);
    logic             get_ready;
    logic             fetch;
    logic             rd_en;
    logic             calc;
    logic             up_sum;
    logic             prog_wt;
    logic             mvm_done;
    logic [CNT_W-1:0] counter;
    logic             skip;

    modport ctrl (
        output get_ready, fetch, rd_en, calc, up_sum, prog_wt, mvm_done, counter,
        input  skip
    );

    modport dp (
        input  get_ready, fetch, rd_en, calc, up_sum, prog_wt, mvm_done, counter,
        output skip
    );
endinterface

// File: rtl/mvm_ctrl_fsm.sv
// Sequencer for one crossbar MVM: walks activation rows, skips zero rows,
// issues the weight-programming strobe and a one-cycle completion pulse.
module mvm_ctrl_fsm
    import mvm_pkg::*;
#(
    parameter int XBAR_SIZE = XBAR_SIZE_DEF,
    parameter int RD_CYCLES = RD_CYCLES_DEF,
    parameter int CNT_W     = $clog2(XBAR_SIZE)
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   mvm_start,
    input  logic   prog_req,
    output logic   busy,
    mvm_bus.ctrl   dp_bus
);

    localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(XBAR_SIZE - 1);
    localparam logic [1:0]       RD_LOAD  = 2'(RD_CYCLES - 1);

    mvm_state_t       state_q, state_d;
    logic [CNT_W-1:0] counter_q, counter_d;
    logic [1:0]       rd_cnt_q, rd_cnt_d;
    mvm_strb_t        strb_q, strb_d;
    logic             busy_q, busy_d;

    // Next-state, row counter and read-latency counter; strobes decode the next state
    // so each one is a flop that is high exactly while its state is current.
    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        rd_cnt_d  = rd_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (prog_req) begin
                    state_d = ST_PROG;
                end else if (mvm_start) begin
                    state_d = ST_INIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PROG: state_d = ST_IDLE;
            ST_INIT: begin
                counter_d = {CNT_W{1'b0}};
                state_d   = ST_FETCH;
            end
            ST_FETCH: begin
                if (dp_bus.skip) begin
                    if (counter_q == LAST_ROW) begin
                        state_d = ST_DONE;
                    end else begin
                        counter_d = counter_q + CNT_W'(1'b1);
                        state_d   = ST_FETCH;
                    end
                end else begin
                    rd_cnt_d = RD_LOAD;
                    state_d  = ST_READ;
                end
            end
            ST_READ: begin
                if (rd_cnt_q == 2'd0) begin
                    state_d = ST_CALC;
                end else begin
                    rd_cnt_d = rd_cnt_q - 2'd1;
                end
            end
            ST_CALC: state_d = ST_ACC;
            ST_ACC: begin
                if (counter_q == LAST_ROW) begin
                    state_d = ST_DONE;
                end else begin
                    counter_d = counter_q + CNT_W'(1'b1);
                    state_d   = ST_FETCH;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        strb_d = strobe_decode(state_d);
        busy_d = (state_d != ST_IDLE);
    end

    // State, counters and registered outputs; reset aborts without a done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            counter_q <= {CNT_W{1'b0}};
            rd_cnt_q  <= 2'd0;
            strb_q    <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            rd_cnt_q  <= rd_cnt_d;
            strb_q    <= strb_d;
            busy_q    <= busy_d;
        end
    end

    assign dp_bus.get_ready = strb_q.get_ready;
    assign dp_bus.fetch     = strb_q.fetch;
    assign dp_bus.rd_en     = strb_q.rd_en;
    assign dp_bus.calc      = strb_q.calc;
    assign dp_bus.up_sum    = strb_q.up_sum;
    assign dp_bus.prog_wt   = strb_q.prog_wt;
    assign dp_bus.mvm_done  = strb_q.mvm_done;
    assign dp_bus.counter   = counter_q;
    assign busy             = busy_q;

endmodule

// File: tb/tb_mvm_ctrl_fsm.sv
// Directed bench for mvm_ctrl_fsm: a table of MVM scenarios on two instances
// (RD_CYCLES 1 and 2) plus hand sequences for programming, ignored starts and abort.
module tb_mvm_ctrl_fsm;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        start1, prog1, busy1;
    logic        start2, prog2, busy2;
    logic [15:0] zmask1, zmask2;
    logic        sel;

    mvm_bus #(.CNT_W(4)) bus1 ();
    mvm_bus #(.CNT_W(4)) bus2 ();

    // Datapath stand-in: activation of the fetched row is zero where the mask bit is set.
    assign bus1.skip = bus1.fetch & zmask1[bus1.counter];
    assign bus2.skip = bus2.fetch & zmask2[bus2.counter];

    mvm_ctrl_fsm #(.XBAR_SIZE(16), .RD_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset), .mvm_start(start1), .prog_req(prog1),
        .busy(busy1), .dp_bus(bus1)
    );
    mvm_ctrl_fsm #(.XBAR_SIZE(16), .RD_CYCLES(2)) dut2 (
        .clk(clk), .reset(reset), .mvm_start(start2), .prog_req(prog2),
        .busy(busy2), .dp_bus(bus2)
    );

    typedef struct packed {
        logic       get_ready, fetch, rd_en, calc, up_sum, prog_wt, mvm_done, busy;
        logic [3:0] counter;
    } obs_t;

    obs_t o1, o2, obs;
    assign o1  = {bus1.get_ready, bus1.fetch, bus1.rd_en, bus1.calc, bus1.up_sum,
                  bus1.prog_wt, bus1.mvm_done, busy1, bus1.counter};
    assign o2  = {bus2.get_ready, bus2.fetch, bus2.rd_en, bus2.calc, bus2.up_sum,
                  bus2.prog_wt, bus2.mvm_done, busy2, bus2.counter};
    assign obs = sel ? o2 : o1;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_quiet(input string name);
        chk(name, int'(obs[11:4]), 0);
    endtask

    task automatic pulse_start(input bit rd2);
        @(negedge clk);
        if (rd2) start2 = 1'b1; else start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        start2 = 1'b0;
    endtask

    // Runs one MVM from the start pulse through done; returns at the cycle after done.
    task automatic run_mvm(input bit rd2, input logic [15:0] mask, input int exp_done,
                           input int nf, input int nr, input int nc, input int na,
                           input string tag);
        int cyc, row, fcnt, rcnt, ccnt, acnt, run, done_at;
        sel = rd2;
        if (rd2) zmask2 = mask; else zmask1 = mask;
        pulse_start(rd2);
        cyc = 1; row = 0; fcnt = 0; rcnt = 0; ccnt = 0; acnt = 0; run = 0; done_at = -1;
        chk({tag, " init"}, int'(obs.get_ready), 1);
        while (cyc < 200 && done_at < 0) begin
            chk({tag, " onehot"}, $countones(obs[11:5]), 1);
            chk({tag, " busy"}, int'(obs.busy), 1);
            if (obs.fetch || obs.rd_en || obs.calc || obs.up_sum)
                chk({tag, " counter"}, int'(obs.counter), row);
            if (obs.rd_en) begin
                rcnt++;
                run++;
            end else if (run > 0) begin
                chk({tag, " rd_width"}, run, rd2 ? 2 : 1);
                run = 0;
            end
            if (obs.fetch) begin
                fcnt++;
                if (mask[row]) row++;
            end
            if (obs.calc) ccnt++;
            if (obs.up_sum) begin
                acnt++;
                row++;
            end
            if (obs.mvm_done) done_at = cyc;
            if (done_at < 0) begin
                @(negedge clk);
                cyc++;
            end
        end
        chk({tag, " done_cycle"}, done_at, exp_done);
        chk({tag, " n_fetch"}, fcnt, nf);
        chk({tag, " n_rd_en"}, rcnt, nr);
        chk({tag, " n_calc"}, ccnt, nc);
        chk({tag, " n_up_sum"}, acnt, na);
        @(negedge clk);
        chk_quiet({tag, " idle_after"});
        chk({tag, " counter_hold"}, int'(obs.counter), 15);
    endtask

    typedef struct {
        bit          rd2;
        logic [15:0] mask;
        int          done_cyc, n_fetch, n_rd, n_calc, n_acc;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int dn, dcyc, pw;
        vecs[0] = '{1'b0, 16'h0000, 66, 16, 16, 16, 16};
        vecs[1] = '{1'b0, 16'hFFFF, 18, 16,  0,  0,  0};
        vecs[2] = '{1'b1, 16'h0088, 74, 16, 28, 14, 14};
        vecs[3] = '{1'b0, 16'h8001, 60, 16, 14, 14, 14};
        vecs[4] = '{1'b1, 16'h0000, 82, 16, 32, 16, 16};
        vecs[5] = '{1'b1, 16'hFFFF, 18, 16,  0,  0,  0};
        vecs[6] = '{1'b0, 16'hAAAA, 42, 16,  8,  8,  8};

        reset = 1'b1;
        start1 = 1'b0; prog1 = 1'b0; start2 = 1'b0; prog2 = 1'b0;
        zmask1 = 16'h0000; zmask2 = 16'h0000; sel = 1'b0;
        repeat (3) @(negedge clk);
        sel = 1'b0;
        chk_quiet("reset dut1");
        chk("reset dut1 counter", int'(obs.counter), 0);
        sel = 1'b1;
        #1 chk_quiet("reset dut2");
        chk("reset dut2 counter", int'(obs.counter), 0);
        reset = 1'b0;
        @(negedge clk);
        chk_quiet("idle dut2");

        for (int i = 0; i < 7; i++)
            run_mvm(vecs[i].rd2, vecs[i].mask, vecs[i].done_cyc, vecs[i].n_fetch,
                    vecs[i].n_rd, vecs[i].n_calc, vecs[i].n_acc, $sformatf("vec%0d", i));

        // prog_req wins over mvm_start; the start is dropped
        sel = 1'b0;
        @(negedge clk);
        prog1 = 1'b1; start1 = 1'b1;
        @(negedge clk);
        prog1 = 1'b0; start1 = 1'b0;
        chk("prog prog_wt", int'(obs.prog_wt), 1);
        chk("prog busy", int'(obs.busy), 1);
        chk("prog no_init", int'(obs.get_ready), 0);
        @(negedge clk);
        chk_quiet("prog back_idle");
        @(negedge clk);
        chk_quiet("prog no_start");

        // start/prog while busy are ignored: exactly one done at the normal cycle
        zmask1 = 16'h0000;
        pulse_start(1'b0);
        dn = 0; dcyc = -1; pw = 0;
        for (int c = 1; c <= 90; c++) begin
            if (obs.mvm_done) begin
                dn++;
                if (dcyc < 0) dcyc = c;
            end
            if (obs.prog_wt) pw++;
            @(negedge clk);
            start1 = (c >= 9 && c <= 13);
            prog1  = (c == 20);
        end
        start1 = 1'b0; prog1 = 1'b0;
        chk("ignore n_done", dn, 1);
        chk("ignore done_cycle", dcyc, 66);
        chk("ignore n_prog", pw, 0);

        // abort during CALC of row 5 (cycle 2 + 5*4 + 2 = 24)
        pulse_start(1'b0);
        for (int c = 1; c < 24; c++) @(negedge clk);
        chk("abort at_calc", int'(obs.calc), 1);
        chk("abort row", int'(obs.counter), 5);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk_quiet("abort idle");
        chk("abort counter", int'(obs.counter), 0);
        dn = 0;
        for (int c = 0; c < 10; c++) begin
            if (obs.mvm_done || obs.busy) dn++;
            @(negedge clk);
        end
        chk("abort no_done", dn, 0);
        run_mvm(1'b0, 16'h0000, 66, 16, 16, 16, 16, "after_abort");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
